// File: rtl/console_port_if.sv
// console_port_if: requester, exit-code and console/exit pin bundle for console_port_arbiter.
interface console_port_if #(parameter int REQ_CNT = 4);
   logic [REQ_CNT-1:0]   req_valid;
   logic [8*REQ_CNT-1:0] req_data;
   logic [REQ_CNT-1:0]   req_lock;
   logic [REQ_CNT-1:0]   req_ready;
   logic                 exit_valid;
   logic [7:0]           exit_code;
   logic                 exit_ready;
   logic [7:0]           port_data;
   logic                 port_update;
   logic [7:0]           exit_data;
   logic                 exit_update;
   logic                 busy;
   logic                 terminated;
   modport master (
      output req_valid, req_data, req_lock, exit_valid, exit_code,
      input  req_ready, exit_ready, port_data, port_update, exit_data, exit_update, busy, terminated
   );
   modport slave (
      input  req_valid, req_data, req_lock, exit_valid, exit_code,
      output req_ready, exit_ready, port_data, port_update, exit_data, exit_update, busy, terminated
   );
endinterface

// File: rtl/console_port_arbiter.sv
// console_port_arbiter: round-robin sharing of a strobed console byte port with message
// locking, plus a one-shot exit-code port that terminates the arbiter.
module console_port_arbiter #(
   parameter int REQ_CNT     = 4,
   parameter int STROBE_HIGH = 2,
   parameter int STROBE_LOW  = 2
) (
   input logic           clk,
   input logic           rst,
   console_port_if.slave bus
);
   localparam int CW = $clog2((STROBE_HIGH > STROBE_LOW ? STROBE_HIGH : STROBE_LOW) + 1);
   localparam int PW = $clog2(REQ_CNT);
   localparam logic [CW-1:0] HI_LOAD = CW'(STROBE_HIGH - 1);
   // the final low cycle is spent in IDLE, so STROBE_LO itself lasts STROBE_LOW-1 cycles
   localparam logic [CW-1:0] LO_LOAD = CW'(STROBE_LOW > 1 ? STROBE_LOW - 2 : 0);
   typedef enum logic [1:0] {IDLE, STROBE_HI, STROBE_LO, TERMINATED} state_t;
   state_t             r_state, w_state_next;
   logic [CW-1:0]      r_cnt, w_cnt_next;
   logic [PW-1:0]      r_rr_ptr, r_owner, w_sel, w_gnt;
   logic               r_locked, r_is_exit;
   logic               w_any, w_exit_acc, w_req_acc, w_hi_done;
   logic [REQ_CNT-1:0] w_ready;
   logic [7:0]         r_port_data, r_exit_data;
   logic               r_port_update, r_exit_update;
   // downward scan so the valid requester nearest above rr_ptr is the last one written
   always_comb begin
      w_sel = '0;
      w_any = 1'b0;
      for (int k = REQ_CNT - 1; k >= 0; k--)
         if (bus.req_valid[(int'(r_rr_ptr) + k) % REQ_CNT]) begin
            w_sel = PW'((int'(r_rr_ptr) + k) % REQ_CNT);
            w_any = 1'b1;
         end
   end
   assign w_gnt = r_locked ? r_owner : w_sel;
   always_comb begin
      w_ready    = '0;
      w_exit_acc = (r_state == IDLE) && bus.exit_valid;
      if (r_state == IDLE && !bus.exit_valid)
         w_ready[w_gnt] = r_locked ? bus.req_valid[r_owner] : w_any;
   end
   assign w_req_acc = |w_ready;
   assign w_hi_done = (r_state == STROBE_HI) && (r_cnt == '0);
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         IDLE: begin
            w_state_next = (w_exit_acc || w_req_acc) ? STROBE_HI : IDLE;
            w_cnt_next   = (w_exit_acc || w_req_acc) ? HI_LOAD : r_cnt;
         end
         STROBE_HI: begin
            w_state_next = !w_hi_done ? STROBE_HI : r_is_exit ? TERMINATED : (STROBE_LOW > 1) ? STROBE_LO : IDLE;
            w_cnt_next   = w_hi_done ? LO_LOAD : r_cnt - 1'b1;
         end
         STROBE_LO: begin
            w_state_next = (r_cnt == '0) ? IDLE : STROBE_LO;
            w_cnt_next   = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
         end
         default: w_state_next = TERMINATED;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_rr_ptr      <= '0;
         r_owner       <= '0;
         r_locked      <= 1'b0;
         r_is_exit     <= 1'b0;
         r_port_data   <= '0;
         r_port_update <= 1'b0;
         r_exit_data   <= '0;
         r_exit_update <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_req_acc) begin
            r_port_data   <= bus.req_data[8*w_gnt +: 8];
            r_port_update <= 1'b1;
            r_rr_ptr      <= (w_gnt == PW'(REQ_CNT - 1)) ? '0 : w_gnt + 1'b1;
            r_owner       <= w_gnt;
            r_locked      <= bus.req_lock[w_gnt];
         end
         if (w_exit_acc) begin
            r_exit_data   <= bus.exit_code;
            r_exit_update <= 1'b1;
            r_is_exit     <= 1'b1;
         end
         if (w_hi_done) begin
            r_port_update <= 1'b0;
            r_exit_update <= 1'b0;
         end
      end
   assign bus.req_ready   = w_ready;
   assign bus.exit_ready  = w_exit_acc;
   assign bus.port_data   = r_port_data;
   assign bus.port_update = r_port_update;
   assign bus.exit_data   = r_exit_data;
   assign bus.exit_update = r_exit_update;
   assign bus.busy        = r_state != IDLE;
   assign bus.terminated  = r_state == TERMINATED;
endmodule

// File: tb/tb_console_port_arbiter.sv
// tb_console_port_arbiter: directed scoreboard bench for console_port_arbiter (defaults and 1/3 strobes).
module tb_console_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   console_port_if #(.REQ_CNT(4)) bus ();
   console_port_if #(.REQ_CNT(4)) b2 ();
   console_port_arbiter #(.REQ_CNT(4), .STROBE_HIGH(2), .STROBE_LOW(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   console_port_arbiter #(.REQ_CNT(4), .STROBE_HIGH(1), .STROBE_LOW(3)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
   int checks = 0, errors = 0, cyc = 0, rises = 0, last_rise = -1;
   logic chk_gap = 1'b0;
   logic prev_upd = 1'b0;
   logic [7:0] prev_data = '0;
   logic [7:0] exp_q[$];
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_rises(input int n, input int budget, input string tag);
      int c = 0;
      while (rises < n && c < budget) begin
         step(1);
         c++;
      end
      check(tag, rises, n);
   endtask
   // console monitor: each rising port_update pops one expected byte
   always @(negedge clk) begin
      if (bus.port_update && !prev_upd) begin
         rises++;
         check("sb_nonempty", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) check("sb_byte", bus.port_data, exp_q.pop_front());
         if (chk_gap && last_rise >= 0) check("rr_gap", cyc - last_rise, 4);
         last_rise = cyc;
      end
      if (bus.port_update && prev_upd) check("data_stable", bus.port_data, prev_data);
      prev_upd  = bus.port_update;
      prev_data = bus.port_data;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int r;
      bus.req_valid = '0; bus.req_data = '0; bus.req_lock = '0; bus.exit_valid = 1'b0; bus.exit_code = '0;
      b2.req_valid = '0; b2.req_data = '0; b2.req_lock = '0; b2.exit_valid = 1'b0; b2.exit_code = '0;
      step(2);
      check("rst_port_data", bus.port_data, 0);
      check("rst_port_update", bus.port_update, 0);
      check("rst_exit_data", bus.exit_data, 0);
      check("rst_exit_update", bus.exit_update, 0);
      check("rst_ready", {bus.exit_ready, bus.req_ready}, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_terminated", bus.terminated, 0);
      rst = 1'b0;
      step(1);
      // single request from requester 2
      exp_q.push_back(8'h41);
      bus.req_data = 32'h0041_0000;
      bus.req_valid = 4'b0100;
      #1 check("single_ready", bus.req_ready, 4'b0100);
      check("single_exit_ready", bus.exit_ready, 0);
      step(1);
      bus.req_valid = '0;
      check("single_upd_n0", bus.port_update, 1);
      check("single_data", bus.port_data, 8'h41);
      check("single_busy", bus.busy, 1);
      check("single_ready_hi", bus.req_ready, 0);
      step(1);
      check("single_upd_n1", bus.port_update, 1);
      step(1);
      check("single_upd_n2", bus.port_update, 0);
      check("single_busy_lo", bus.busy, 1);
      step(1);
      check("single_upd_n3", bus.port_update, 0);
      check("single_idle", bus.busy, 0);
      bus.req_valid = 4'b1001;
      #1 check("rr_ptr_3", bus.req_ready, 4'b1000);
      bus.req_valid = '0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      // round robin, all valid
      r = rises;
      last_rise = -1;
      chk_gap = 1'b1;
      foreach (exp_q[i]) check("sb_empty_pre_rr", 1, 0);
      exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
      exp_q.push_back(8'h13); exp_q.push_back(8'h10);
      bus.req_data = 32'h1312_1110;
      bus.req_valid = 4'hF;
      wait_rises(r + 5, 40, "rr_count");
      bus.req_valid = '0;
      chk_gap = 1'b0;
      step(3);
      check("rr_sb_drained", exp_q.size(), 0);
      // locked message from requester 1 while requester 0 waits
      r = rises;
      exp_q.push_back(8'h41);
      bus.req_data = 32'h0000_415A;
      bus.req_lock = 4'b0010;
      bus.req_valid = 4'b0011;
      #1 check("lock_first_ready", bus.req_ready, 4'b0010);
      wait_rises(r + 1, 20, "lock_a");
      bus.req_valid = 4'b0001;
      bus.req_lock = '0;
      step(6);
      check("lock_hold_busy", bus.busy, 0);
      check("lock_hold_ready", bus.req_ready, 0);
      check("lock_hold_rises", rises, r + 1);
      exp_q.push_back(8'h42);
      exp_q.push_back(8'h5A);
      bus.req_data = 32'h0000_425A;
      bus.req_valid = 4'b0011;
      #1 check("lock_b_ready", bus.req_ready, 4'b0010);
      wait_rises(r + 2, 20, "lock_b");
      bus.req_valid = 4'b0001;
      wait_rises(r + 3, 20, "lock_after");
      bus.req_valid = '0;
      step(3);
      // reset one cycle after an accept
      r = rises;
      exp_q.push_back(8'h55);
      bus.req_data = 32'h0055_0000;
      bus.req_valid = 4'b0100;
      wait_rises(r + 1, 20, "mid_accept");
      bus.req_valid = '0;
      check("mid_upd_before", bus.port_update, 1);
      rst = 1'b1;
      #1 check("mid_upd_async", bus.port_update, 0);
      check("mid_data_rst", bus.port_data, 0);
      check("mid_busy_rst", bus.busy, 0);
      step(1);
      rst = 1'b0;
      exp_q.push_back(8'h61);
      bus.req_data = 32'h6300_6100;
      bus.req_valid = 4'b1010;
      #1 check("mid_restart_ready", bus.req_ready, 4'b0010);
      wait_rises(r + 2, 20, "mid_restart");
      bus.req_valid = '0;
      step(4);
      // exit wins over a simultaneous byte request
      bus.req_data = 32'h6300_0000;
      bus.req_valid = 4'b1000;
      bus.exit_code = 8'h07;
      bus.exit_valid = 1'b1;
      #1 check("exit_ready", bus.exit_ready, 1);
      check("exit_req_ready", bus.req_ready, 0);
      step(1);
      bus.exit_valid = 1'b0;
      check("exit_upd_n0", bus.exit_update, 1);
      check("exit_data", bus.exit_data, 8'h07);
      check("exit_term_n0", bus.terminated, 0);
      step(1);
      check("exit_upd_n1", bus.exit_update, 1);
      check("exit_term_n1", bus.terminated, 0);
      step(1);
      check("exit_upd_n2", bus.exit_update, 0);
      check("exit_term_n2", bus.terminated, 1);
      for (int k = 0; k < 4; k++) begin
         check("term_req_ready", bus.req_ready, 0);
         check("term_exit_ready", bus.exit_ready, 0);
         check("term_port_update", bus.port_update, 0);
         check("term_exit_data", bus.exit_data, 8'h07);
         check("term_terminated", bus.terminated, 1);
         step(1);
      end
      bus.req_valid = '0;
      check("final_sb_drained", exp_q.size(), 0);
      // STROBE_HIGH=1, STROBE_LOW=3 instance
      b2.req_data = 32'h1312_1110;
      b2.req_valid = 4'hF;
      step(1);
      for (int k = 0; k < 12; k++) begin
         check("sweep_update", b2.port_update, 32'((k % 4) == 0));
         if ((k % 4) == 0) check("sweep_data", b2.port_data, 8'h10 + k / 4);
         step(1);
      end
      b2.req_valid = '0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
